// File: rtl/vga_pkg.sv
// Shared header codes, channel/address limits and parser state encoding
// for the UART colour-command parser.
package vga_pkg;

  localparam logic [7:0] HDR_WRITE = 8'h57;
  localparam logic [7:0] HDR_NEXT  = 8'h4E;
  localparam logic [7:0] CH_FIRST  = 8'h30;
  localparam logic [7:0] CH_LAST   = 8'h33;
  localparam logic [3:0] ADDR_MIN  = 4'd3;
  localparam logic [3:0] ADDR_MAX  = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_CH  = 3'd1,
    ST_GET_PL  = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_NEXT_HI = 3'd4,
    ST_NEXT_LO = 3'd5
  } state_t;

  function automatic logic is_channel(input logic [7:0] b);
    return (b >= CH_FIRST) && (b <= CH_LAST);
  endfunction

  function automatic logic addr_ok(input logic [3:0] a);
    return (a >= ADDR_MIN) && (a <= ADDR_MAX);
  endfunction

endpackage

// File: rtl/cmd_parser.sv
// Parses 3-byte UART frames ('W' write / 'N' next-preset) into colour
// register-file write requests and preset-advance pulses.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a 'W' or 'N' header; other bytes ignored
// ST_GET_CH  | header seen, waiting for channel byte '0'..'3'
// ST_GET_PL  | channel seen, waiting for payload byte
// ST_ISSUE   | valid high, waiting up to ACK_CYC cycles for ack
// ST_NEXT_HI | color_next high for NEXT_HOLD cycles
// ST_NEXT_LO | color_next low for NEXT_HOLD cycles before returning idle
module cmd_parser
  import vga_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [7:0]  ACK_CYC     = 8'd16,
  parameter logic [3:0]  NEXT_HOLD   = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       ack,
  output logic [1:0] channel,
  output logic [3:0] address,
  output logic [3:0] data,
  output logic       valid,
  output logic       color_next,
  output logic       busy,
  output logic       err
);

  localparam logic [15:0] LD_TIMEOUT = TIMEOUT_CYC - 16'd1;
  localparam logic [15:0] LD_ACK     = {8'd0, ACK_CYC} - 16'd1;
  localparam logic [15:0] LD_HOLD    = {12'd0, NEXT_HOLD} - 16'd1;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_is_write, w_is_write_nxt;
  logic [1:0]  r_ch_pend, w_ch_pend_nxt;
  logic [1:0]  r_channel, w_channel_nxt;
  logic [3:0]  r_address, w_address_nxt;
  logic [3:0]  r_data, w_data_nxt;
  logic        r_err, w_err_nxt;
  logic        w_tc;

  assign w_tc = (r_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 16'd0;
      r_is_write <= 1'b0;
      r_ch_pend  <= 2'd0;
      r_channel  <= 2'd0;
      r_address  <= 4'd0;
      r_data     <= 4'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_is_write <= w_is_write_nxt;
      r_ch_pend  <= w_ch_pend_nxt;
      r_channel  <= w_channel_nxt;
      r_address  <= w_address_nxt;
      r_data     <= w_data_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // One shared down-counter: byte timeout, ack wait and hold dwell.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_is_write_nxt = r_is_write;
    w_ch_pend_nxt  = r_ch_pend;
    w_channel_nxt  = r_channel;
    w_address_nxt  = r_address;
    w_data_nxt     = r_data;
    w_err_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid && ((rx_byte == HDR_WRITE) || (rx_byte == HDR_NEXT))) begin
          w_state_nxt    = ST_GET_CH;
          w_cnt_nxt      = LD_TIMEOUT;
          w_is_write_nxt = (rx_byte == HDR_WRITE);
        end
      end
      ST_GET_CH: begin
        if (rx_valid) begin
          if (is_channel(rx_byte)) begin
            w_state_nxt   = ST_GET_PL;
            w_cnt_nxt     = LD_TIMEOUT;
            w_ch_pend_nxt = rx_byte[1:0];
          end else begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end
        end else if (w_tc) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_GET_PL: begin
        if (rx_valid) begin
          if (!r_is_write) begin
            w_state_nxt   = ST_NEXT_HI;
            w_cnt_nxt     = LD_HOLD;
            w_channel_nxt = r_ch_pend;
          end else if (addr_ok(rx_byte[7:4])) begin
            w_state_nxt   = ST_ISSUE;
            w_cnt_nxt     = LD_ACK;
            w_channel_nxt = r_ch_pend;
            w_address_nxt = rx_byte[7:4];
            w_data_nxt    = rx_byte[3:0];
          end else begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end
        end else if (w_tc) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_ISSUE: begin
        w_err_nxt = rx_valid;
        if (ack) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tc) begin
          w_state_nxt = ST_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_NEXT_HI: begin
        w_err_nxt = rx_valid;
        if (w_tc) begin
          w_state_nxt = ST_NEXT_LO;
          w_cnt_nxt   = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_NEXT_LO: begin
        w_err_nxt = rx_valid;
        if (w_tc) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign channel    = r_channel;
  assign address    = r_address;
  assign data       = r_data;
  assign err        = r_err;
  assign valid      = (r_state == ST_ISSUE);
  assign color_next = (r_state == ST_NEXT_HI);
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cmd_parser.sv
// Randomized frame-level bench for cmd_parser against a behavioural
// outcome model derived from the frame rules.
module tb_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] channel;
  logic [3:0] address;
  logic [3:0] data;
  logic       valid;
  logic       color_next;
  logic       busy;
  logic       err;

  cmd_parser dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .ack(ack),
    .channel(channel), .address(address), .data(data), .valid(valid),
    .color_next(color_next), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_total = 0;

  always @(negedge clk) if (err === 1'b1) err_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  // Expected outcome computed from the frame rules, not from parser internals.
  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] chb, input logic [7:0] plb,
                           input int gap, input int ack_lat, input int drop_at);
    int e0, nv, nhi, nlo, k, exp_err, exp_v;
    bit is_w, is_n, ch_ok, ad_ok, hold_ok;
    logic [3:0] a;
    logic [1:0] exp_ch;
    is_w   = (hdr == 8'h57);
    is_n   = (hdr == 8'h4E);
    ch_ok  = (chb >= 8'h30) && (chb <= 8'h33);
    a      = plb[7:4];
    ad_ok  = (a >= 4'd3) && (a <= 4'd8);
    exp_ch = 2'(chb - 8'h30);
    e0     = err_total;
    send_byte(hdr);
    if (!is_w && !is_n) begin
      check("junk_hdr_idle", 32'(busy), 0);
      idle(2);
      check("junk_hdr_err", 32'(err_total - e0), 0);
      return;
    end
    idle(gap);
    send_byte(chb);
    if (!ch_ok) begin
      check("bad_ch_idle", 32'(busy), 0);
      check("bad_ch_err_now", 32'(err), 1);
      idle(2);
      check("bad_ch_err_cnt", 32'(err_total - e0), 1);
      return;
    end
    idle(gap);
    send_byte(plb);
    if (is_w && !ad_ok) begin
      check("bad_addr_idle", 32'(busy), 0);
      check("bad_addr_valid", 32'(valid), 0);
      check("bad_addr_err_now", 32'(err), 1);
      idle(2);
      check("bad_addr_err_cnt", 32'(err_total - e0), 1);
      return;
    end
    nv = 0; nhi = 0; nlo = 0; k = 0; hold_ok = 1'b1;
    while (busy === 1'b1 && k < 100) begin
      if (valid === 1'b1) begin
        nv++;
        if (channel !== exp_ch || address !== a || data !== plb[3:0]) hold_ok = 1'b0;
        ack = (nv == ack_lat + 1);
      end else begin
        ack = 1'($urandom_range(0, 1));
      end
      if (color_next === 1'b1) nhi++;
      else if (valid !== 1'b1) nlo++;
      rx_valid = (k == drop_at);
      rx_byte  = 8'($urandom_range(0, 255));
      cyc();
      k++;
    end
    ack = 1'b0;
    rx_valid = 1'b0;
    check("frame_done", 32'(busy), 0);
    if (is_w) begin
      exp_v   = (ack_lat < 16) ? ack_lat + 1 : 16;
      exp_err = (ack_lat < 16) ? 0 : 1;
      check("valid_cycles", 32'(nv), 32'(exp_v));
      check("write_fields_held", 32'(hold_ok), 1);
      check("next_in_write", 32'(nhi), 0);
    end else begin
      exp_err = (drop_at >= 0 && drop_at < 8) ? 1 : 0;
      check("next_hi_cycles", 32'(nhi), 4);
      check("next_lo_cycles", 32'(nlo), 4);
      check("valid_in_next", 32'(nv), 0);
    end
    idle(2);
    check("frame_err_cnt", 32'(err_total - e0), 32'(exp_err));
  endtask

  initial begin
    int e0, kind, gap, lat, drop;
    logic [7:0] h, c, p;
    logic [3:0] a;

    idle(3);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cnext", 32'(color_next), 0);
    check("rst_fields", {20'd0, channel, address, data}, 0);
    rst = 1'b1;
    idle(2);

    run_frame(8'h57, 8'h32, 8'h5A, 0, 1, -1);
    check("d1_channel", 32'(channel), 2);
    check("d1_address", 32'(address), 5);
    check("d1_data", 32'(data), 32'hA);
    run_frame(8'h4E, 8'h31, 8'h00, 0, 0, -1);
    run_frame(8'h57, 8'h30, 8'h9F, 0, 0, -1);
    run_frame(8'h57, 8'h31, 8'h4C, 0, 99, -1);

    e0 = err_total;
    send_byte(8'h57);
    idle(49999);
    check("tmo_still_busy", 32'(busy), 1);
    idle(1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_err_now", 32'(err), 1);
    idle(2);
    check("tmo_err_cnt", 32'(err_total - e0), 1);
    run_frame(8'h57, 8'h33, 8'h87, 2, 3, -1);

    send_byte(8'h57);
    send_byte(8'h32);
    send_byte(8'h5A);
    check("rst_mid_valid_pre", 32'(valid), 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_fields", {20'd0, channel, address, data}, 0);
    check("rst_mid_err_cnext", {30'd0, err, color_next}, 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    run_frame(8'h57, 8'h31, 8'h36, 1, 0, -1);

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 5);
      lat  = $urandom_range(0, 20);
      drop = -1;
      h = 8'h57;
      c = 8'(8'h30 + 8'($urandom_range(0, 3)));
      p = 8'($urandom_range(0, 255));
      case (kind)
        0: begin
          h = 8'h57;
          while (h == 8'h57 || h == 8'h4E) h = 8'($urandom_range(0, 255));
        end
        1: begin
          c = 8'h30;
          while (c >= 8'h30 && c <= 8'h33) c = 8'($urandom_range(0, 255));
        end
        2: begin
          a = 4'd3;
          while (a >= 4'd3 && a <= 4'd8) a = 4'($urandom_range(0, 15));
          p = {a, 4'($urandom_range(0, 15))};
        end
        3, 4, 5: p = {4'($urandom_range(3, 8)), 4'($urandom_range(0, 15))};
        default: begin
          h = 8'h4E;
          drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
        end
      endcase
      run_frame(h, c, p, gap, lat, drop);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
